// File: rtl/bin_bcd_display_ctrl.sv
// 8-bit binary to 3-digit BCD (double-dabble) with multiplexed 7-seg scan.
// Optional BLANK_LZ_EN: blank leading-zero hundreds/tens digits.
module bin_bcd_display_ctrl #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  value,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [19:0] RMAX = 20'(REFRESH_DIV - 1);

   state_t      state;
   logic [7:0]  shreg;
   logic [11:0] scratch;
   logic [11:0] adj;
   logic [2:0]  step;
   logic [19:0] rcnt;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic        blank;

   always_comb begin
      adj = scratch;
      for (int i = 0; i < 3; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         step    <= '0;
         bcd     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (load) begin
                  shreg   <= value;
                  scratch <= '0;
                  step    <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               scratch <= {adj[10:0], shreg[7]};
               shreg   <= {shreg[6:0], 1'b0};
               step    <= step + 3'd1;
               // eighth shift: result is the shifted-in scratch
               if (step == 3'd7) begin
                  bcd   <= {adj[10:0], shreg[7]};
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt <= '0;
         idx  <= '0;
      end else if (rcnt == RMAX) begin
         rcnt <= '0;
         case (idx)
            2'd0:    idx <= 2'd1;
            2'd1:    idx <= 2'd2;
            default: idx <= 2'd0;
         endcase
      end else begin
         rcnt <= rcnt + 20'd1;
      end
   end

   always_comb begin
      an    = 3'b110;
      nib   = bcd[3:0];
      blank = 1'b0;
      case (idx)
         2'd1: begin
            an  = 3'b101;
            nib = bcd[7:4];
`ifdef BLANK_LZ_EN
            blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
`endif
         end
         2'd2: begin
            an  = 3'b011;
            nib = bcd[11:8];
`ifdef BLANK_LZ_EN
            blank = (bcd[11:8] == 4'd0);
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      seg = 7'b1111111;
      if (!blank) begin
         case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_bcd_display_ctrl.sv
// Scoreboard bench for bin_bcd_display_ctrl (REFRESH_DIV=4).
// Expected BCD is pushed on load and popped at each done pulse.
module tb_bin_bcd_display_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  value;
   logic        load;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [2:0]  an;
   logic [6:0]  seg;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   logic [11:0] q[$];

   bin_bcd_display_ctrl #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .busy(busy), .done(done), .bcd(bcd), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] segof(input logic [3:0] d);
      logic [6:0] t[10];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return (d < 4'd10) ? t[d] : 7'b1111111;
   endfunction

   task automatic convert(input logic [7:0] v, input string tag);
      int n;
      logic [11:0] e;
      @(negedge clk);
      value = v;
      load  = 1'b1;
      q.push_back(to_bcd(int'(v)));
      n = 0;
      do begin
         @(negedge clk);
         load = 1'b0;
         n++;
      end while (!done && n < 20);
      e = (q.size() > 0) ? q.pop_front() : 12'hfff;
      compared++;
      if (done !== 1'b1 || bcd !== e) begin
         mismatched++;
         $display("FAIL %s: bcd=%h done=%b, required bcd=%h done=1",
                  tag, bcd, done, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; value = 8'd0;
      repeat (2) @(negedge clk);
      compared++;
      if ({busy, done, bcd, an, seg} !== {1'b0, 1'b0, 12'h000, 3'b110, 7'b1000000}) begin
         mismatched++;
         $display("FAIL reset: busy=%b done=%b bcd=%h an=%b seg=%b, required 0 0 000 110 1000000",
                  busy, done, bcd, an, seg);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int nb;
      logic [11:0] e;
      @(negedge clk);
      value = 8'd255; load = 1'b1;
      q.push_back(to_bcd(255));
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (done) break;
         if (busy) nb++;
      end
      compared++;
      if (nb !== 8) begin
         mismatched++;
         $display("FAIL single_busy_len: %0d cycles, required 8", nb);
      end
      e = (q.size() > 0) ? q.pop_front() : 12'hfff;
      compared++;
      if (done !== 1'b1 || busy !== 1'b0 || bcd !== e) begin
         mismatched++;
         $display("FAIL single_result: done=%b busy=%b bcd=%h, required 1 0 %h",
                  done, busy, bcd, e);
      end
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL single_after: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int vals[6] = '{0, 9, 10, 99, 100, 128};
      int k, got, last;
      logic [11:0] e;
      @(negedge clk);
      value = 8'(vals[0]); load = 1'b1;
      q.push_back(to_bcd(vals[0]));
      k = 1; got = 0; last = 0;
      for (int c = 0; c < 200 && got < 6; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (done) begin
            e = (q.size() > 0) ? q.pop_front() : 12'hfff;
            compared++;
            if (bcd !== e) begin
               mismatched++;
               $display("FAIL b2b_bcd[%0d]: bcd=%h, required %h", got, bcd, e);
            end
            if (got > 0) begin
               compared++;
               if (cyc - last !== 9) begin
                  mismatched++;
                  $display("FAIL b2b_spacing[%0d]: %0d cycles, required 9", got, cyc - last);
               end
            end
            last = cyc;
            got++;
            if (k < 6) begin
               value = 8'(vals[k]); load = 1'b1;
               q.push_back(to_bcd(vals[k]));
               k++;
            end
         end
      end
      compared++;
      if (got !== 6) begin
         mismatched++;
         $display("FAIL b2b_count: %0d done pulses, required 6", got);
      end
      q.delete();
   endtask

   task automatic test_ignore_load();
      int nb, nd;
      logic [11:0] e;
      @(negedge clk);
      value = 8'd200; load = 1'b1;
      q.push_back(to_bcd(200));
      nb = 0; nd = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (busy) begin
            nb++;
            if (nb == 3 || nb == 7) begin
               value = 8'd17; load = 1'b1;
            end
         end
         if (done) begin
            nd++;
            if (nd == 1) begin
               e = (q.size() > 0) ? q.pop_front() : 12'hfff;
               compared++;
               if (bcd !== e) begin
                  mismatched++;
                  $display("FAIL ignore_bcd: bcd=%h, required %h", bcd, e);
               end
            end
         end
      end
      compared++;
      if (nd !== 1 || bcd !== 12'h200) begin
         mismatched++;
         $display("FAIL ignore_pulses: %0d done pulses bcd=%h, required 1 and 200", nd, bcd);
      end
      q.delete();
   endtask

   task automatic test_reset_mid();
      int nd;
      // leave bcd at 000 so the abort is visible against reset values
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      value = 8'd173; load = 1'b1;
      q.push_back(to_bcd(173));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         load = 1'b0;
      end
      rst = 1'b1;
      #1;
      compared++;
      if ({busy, done, bcd, an, seg} !== {1'b0, 1'b0, 12'h000, 3'b110, 7'b1000000}) begin
         mismatched++;
         $display("FAIL midreset: busy=%b done=%b bcd=%h an=%b seg=%b, required 0 0 000 110 1000000",
                  busy, done, bcd, an, seg);
      end
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      compared++;
      if (nd !== 0 || bcd !== 12'h000) begin
         mismatched++;
         $display("FAIL midreset_nodone: %0d pulses bcd=%h, required 0 and 000", nd, bcd);
      end
      convert(8'd173, "midreset_reload");
   endtask

   task automatic test_scan();
      int vals[4] = '{42, 5, 105, 255};
      logic [11:0] b;
      logic [6:0]  es[3];
      logic [2:0]  ea[3];
      logic [2:0]  prev;
      bit found;
      int s;
      ea = '{3'b110, 3'b101, 3'b011};
      foreach (vals[v]) begin
         convert(8'(vals[v]), "scan_load");
         b = to_bcd(vals[v]);
         es[0] = segof(b[3:0]);
         es[1] = segof(b[7:4]);
         es[2] = segof(b[11:8]);
`ifdef BLANK_LZ_EN
         if (b[11:8] == 4'd0) es[2] = 7'b1111111;
         if (b[11:4] == 8'd0) es[1] = 7'b1111111;
`endif
         found = 1'b0;
         prev = an;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (an == 3'b110 && prev != 3'b110) begin
               found = 1'b1;
               break;
            end
            prev = an;
         end
         compared++;
         if (!found) begin
            mismatched++;
            $display("FAIL scan_sync[%0d]: an stuck at %b, required 110 slot start", vals[v], an);
         end
         for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            s = (j / 4) % 3;
            compared++;
            if (an !== ea[s] || seg !== es[s]) begin
               mismatched++;
               $display("FAIL scan[%0d] cyc %0d: an=%b seg=%b, required an=%b seg=%b",
                        vals[v], j, an, seg, ea[s], es[s]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value = 8'd0;
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_load();
      test_reset_mid();
      test_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bin_bcd_display_ctrl.md
# bin_bcd_display_ctrl

Sequential controller that turns an 8-bit binary value (0–255) into three BCD digits and drives a time-multiplexed three-digit seven-segment display. Conversion uses an iterative shift-and-add-3 (double-dabble) sequence, started by a request/busy/done handshake. Display scanning runs continuously from the last completed result. The block sits between the switch/PWM-duty source and the board's digit-select and segment pins, replacing per-digit combinational divide/modulo logic.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  8  binary operand; sampled only when a load is accepted.
- load  in  1  conversion request; honoured only in IDLE or DONE.
- busy  out  1  high while the block is shifting.
- done  out  1  one-cycle pulse when a new result is in bcd.
- bcd  out  12  latched result {hundreds[11:8], tens[7:4], units[3:0]}.
- an  out  3  digit enables, active-low one-hot; an[0]=units, an[1]=tens, an[2]=hundreds.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 → capture value into an 8-bit shift register, clear the 12-bit scratch, clear the 3-bit step counter, go to SHIFT.
  - SHIFT: on each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shreg} left by one. After step 7 (the 8th shift), copy scratch to bcd and go to DONE.
  - DONE: done=1 for this single cycle. load=1 is handled exactly as in IDLE, so back-to-back conversions are possible. Otherwise go to IDLE.
- load during SHIFT is ignored and is not queued.
- bcd holds its value until the next completion. The hundreds nibble is always 0–2.
- Scan: a refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→0. Index 3 is unreachable; if it ever occurs, treat it as 0.
- an and seg are combinational from the digit index and bcd. They change only on an index change or a bcd update.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles >9 are impossible; blank (1111111) if one ever occurs.

## Timing
- Reset values: state IDLE, busy=0, done=0, bcd=12'h000, refresh counter 0, digit index 0, an=3'b110, seg=7'b1000000.
- Latency: load accepted at edge E0 → busy=1 from E1 through E8 (8 cycles). bcd is updated at E8. done=1 for the cycle from E8 to E9. busy=0 and done=0 after E9 unless a new load was accepted at E9.
- Maximum throughput: one conversion every 9 cycles.
- Reset asserted mid-SHIFT: the conversion is aborted and all registers return to their reset values immediately. No done pulse is produced.
- A bcd update during a scan slot changes seg within the same slot. Slot timing is unaffected.
- Each digit is enabled for exactly REFRESH_DIV cycles. The full frame is 3·REFRESH_DIV cycles.

## Configuration
- BLANK_LZ_EN defined:
  - The hundreds digit is blanked (seg=1111111, its an bit still asserted) when hundreds=0.
  - The tens digit is blanked when both hundreds=0 and tens=0.
  - The units digit is never blanked.
- BLANK_LZ_EN undefined: all three digits always show their decoded value, including leading zeros.
- Reset seg value is 1000000 in both builds, because index 0 is the units digit.

## Test plan
- Reset, then load value=255 → busy high for 8 cycles; bcd=12'h255 with done=1 in the cycle after the 8th busy cycle; done low the following cycle.
- Load 0, then 9, 10, 99, 100, 128 back-to-back, each load issued in the DONE cycle → bcd 000, 009, 010, 099, 100, 128; done pulses spaced exactly 9 cycles apart.
- Load 200, then pulse load with value=17 on busy cycles 3 and 7 → both ignored; bcd=12'h200, only one done pulse.
- Assert rst on the 5th SHIFT cycle of a load with value=173 → bcd stays 000, no done, an=110, seg=1000000; the next load of 173 gives 12'h173.
- REFRESH_DIV=4, bcd=12'h042 → an sequence 110,101,011 every 4 cycles, repeating; seg = 0100100, 0011001, then 1000000 (no macro) or 1111111 (BLANK_LZ_EN).
- BLANK_LZ_EN, value=5 → hundreds and tens blank, units 0010010; value=105 → tens shows 1000000 because hundreds≠0.
